operand_fetch: RTL

- Upstream operand stage of the Simple RISC Machine datapath.
- Holds the register file and the A/B operand latches, the shifter and the source-select muxes.
- Runs a small fetch FSM that reads Rn and Rm over successive cycles, then holds Ain/Bin stable for the ALU under a valid/ack handshake.
- Writeback from the C register or memory arrives on a dedicated write port.

---
 rtl/operand_fetch_if.sv | 36 +++
 rtl/operand_fetch.sv | 108 ++++++++++
 2 files changed

// File: rtl/operand_fetch_if.sv
// Operand-fetch bus: request/control fields in, ALU operands out, plus the register-file write port.
// The master drives requests and writes; the slave (operand_fetch) returns Ain/Bin under valid/ack.
interface operand_fetch_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) ();
    logic              start;
    logic              ready;
    logic [ADDR_W-1:0] readnum_n;
    logic [ADDR_W-1:0] readnum_m;
    logic [1:0]        shift;
    logic              asel;
    logic              bsel;
    logic [WIDTH-1:0]  sximm5;
    logic              write;
    logic [ADDR_W-1:0] writenum;
    logic [WIDTH-1:0]  data_in;
    logic [WIDTH-1:0]  Ain;
    logic [WIDTH-1:0]  Bin;
    logic              valid;
    logic              ack;

    // Handshake: start is taken only on an edge where ready=1; valid stays high with Ain/Bin
    // frozen until an edge samples ack=1, and drops on the cycle after that edge.
    modport master (
        output start, readnum_n, readnum_m, shift, asel, bsel, sximm5,
        output write, writenum, data_in, ack,
        input  ready, Ain, Bin, valid
    );

    modport slave (
        input  start, readnum_n, readnum_m, shift, asel, bsel, sximm5,
        input  write, writenum, data_in, ack,
        output ready, Ain, Bin, valid
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand stage of the Simple RISC Machine: register file, A/B latches, shifter and source muxes.
// A four-state FSM reads Rn then Rm on successive edges and holds the operands until ack.
module operand_fetch #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    operand_fetch_if.slave   bus,
    output logic [1:0]       dbg_state
);
    localparam int NREGS = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ_A = 2'd1,
        READ_B = 2'd2,
        OUT    = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  rf [NREGS];
    logic [WIDTH-1:0]  a_q, b_q, b_shift;
    logic [WIDTH-1:0]  a_rd, b_rd;
    logic [WIDTH-1:0]  sximm5_q;
    logic [ADDR_W-1:0] rn_q, rm_q;
    logic [1:0]        shift_q;
    logic              asel_q, bsel_q;
    logic              accept;

    assign accept = (state == IDLE) && bus.start;

    // Same-edge write to the register being read wins, so A/B see the new value.
    assign a_rd = (bus.write && (bus.writenum == rn_q)) ? bus.data_in : rf[rn_q];
    assign b_rd = (bus.write && (bus.writenum == rm_q)) ? bus.data_in : rf[rm_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = READ_A;
            READ_A:  state_nxt = READ_B;
            READ_B:  state_nxt = OUT;
            OUT:     if (bus.ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (bus.write) begin
            rf[bus.writenum] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rn_q     <= '0;
            rm_q     <= '0;
            shift_q  <= '0;
            asel_q   <= 1'b0;
            bsel_q   <= 1'b0;
            sximm5_q <= '0;
        end else if (accept) begin
            rn_q     <= bus.readnum_n;
            rm_q     <= bus.readnum_m;
            shift_q  <= bus.shift;
            asel_q   <= bus.asel;
            bsel_q   <= bus.bsel;
            sximm5_q <= bus.sximm5;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (state == READ_A) a_q <= a_rd;
            if (state == READ_B) b_q <= b_rd;
        end
    end

    always_comb begin
        b_shift = b_q;
        case (shift_q)
            2'b01:   b_shift = {b_q[WIDTH-2:0], 1'b0};
            2'b10:   b_shift = {1'b0, b_q[WIDTH-1:1]};
            2'b11:   b_shift = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
            default: b_shift = b_q;
        endcase
    end

    // Muxes are live in every state; consumers qualify Ain/Bin with valid.
    assign bus.Ain   = asel_q ? '0 : a_q;
    assign bus.Bin   = bsel_q ? sximm5_q : b_shift;
    assign bus.ready = (state == IDLE);
    assign bus.valid = (state == OUT);
    assign dbg_state = state;
endmodule
